// File: rtl/dsp_post_adder_acc.sv
// 48-bit post-adder/subtracter and accumulator stage of a DSP48A1-style slice.
// Optional M, C, OPMODE, CARRYIN, P and CARRYOUT pipeline registers; P feeds back for accumulation.
module dsp_post_adder_acc #(
    parameter int unsigned MREG        = 1,
    parameter int unsigned CREG        = 1,
    parameter int unsigned OPMODEREG   = 1,
    parameter int unsigned CARRYINREG  = 1,
    parameter int unsigned PREG        = 1,
    parameter int unsigned CARRYOUTREG = 1,
    parameter string       CARRYINSEL  = "OPMODE5"
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_m,
    input  logic        ce_c,
    input  logic        ce_opmode,
    input  logic        ce_carryin,
    input  logic        ce_p,
    input  logic [35:0] m,
    input  logic [47:0] c,
    input  logic [47:0] pcin,
    input  logic [47:0] dab,
    input  logic        carryin,
    input  logic [7:0]  opmode,
    output logic [47:0] p,
    output logic [47:0] pcout,
    output logic        carryout,
    output logic        carryoutf
);

    logic [35:0] m_q, m_s;
    logic [47:0] c_q, c_s;
    logic [7:0]  opmode_q, opmode_s;
    logic        cin_raw, cin_q, cin_s;
    logic [47:0] p_q, p_fb;
    logic        co_q;
    logic [47:0] x_mux, z_mux;
    logic [48:0] result;
    logic        unused_opmode;

    // Input pipeline registers; a disabled stage is bypassed by the muxes below.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_q      <= '0;
            c_q      <= '0;
            opmode_q <= '0;
            cin_q    <= 1'b0;
        end else begin
            if (ce_m)       m_q      <= m;
            if (ce_c)       c_q      <= c;
            if (ce_opmode)  opmode_q <= opmode;
            if (ce_carryin) cin_q    <= cin_raw;
        end
    end

    assign m_s      = (MREG != 0)      ? m_q      : m;
    assign c_s      = (CREG != 0)      ? c_q      : c;
    assign opmode_s = (OPMODEREG != 0) ? opmode_q : opmode;

    // Carry source is taken ahead of the opmode register so both stages stay aligned.
    assign cin_raw = (CARRYINSEL == "CARRYIN") ? carryin : opmode[5];
    assign cin_s   = (CARRYINREG != 0) ? cin_q : cin_raw;

    // Without PREG there is no P register to feed back, so selections of P read as zero.
    assign p_fb = (PREG != 0) ? p_q : '0;

    always_comb begin
        x_mux = '0;
        case (opmode_s[1:0])
            2'b00:   x_mux = '0;
            2'b01:   x_mux = {{12{m_s[35]}}, m_s};
            2'b10:   x_mux = p_fb;
            default: x_mux = dab;
        endcase
    end

    always_comb begin
        z_mux = '0;
        case (opmode_s[3:2])
            2'b00:   z_mux = '0;
            2'b01:   z_mux = pcin;
            2'b10:   z_mux = p_fb;
            default: z_mux = c_s;
        endcase
    end

    always_comb begin
        result = '0;
        if (opmode_s[7]) begin
            result = {1'b0, z_mux} - ({1'b0, x_mux} + {48'b0, cin_s});
        end else begin
            result = {1'b0, z_mux} + {1'b0, x_mux} + {48'b0, cin_s};
        end
    end

    assign unused_opmode = ^{opmode_s[6], opmode_s[4]};

    always_ff @(posedge clk) begin
        if (reset) begin
            p_q  <= '0;
            co_q <= 1'b0;
        end else if (ce_p) begin
            p_q  <= result[47:0];
            co_q <= result[48];
        end
    end

    assign p         = (PREG != 0)        ? p_q  : result[47:0];
    assign pcout     = p;
    assign carryout  = (CARRYOUTREG != 0) ? co_q : result[48];
    assign carryoutf = carryout;

endmodule

// File: doc/dsp_post_adder_acc.md
Name: dsp_post_adder_acc

Overview:
- 48-bit post-adder/subtracter and accumulator stage of the DSP48A1 slice.
- Consumes the 36-bit multiplier product, the C operand, the cascade input PCIN and the D:A:B concatenation.
- Selects X and Z operands by OPMODE and computes Z ± (X + CIN).
- Produces P, PCOUT and CARRYOUT, which feed the downstream 48-bit output register/mux stage.
- Contains its own optional M, C, OPMODE, CARRYIN, P and CARRYOUT pipeline registers, with accumulate feedback from P.

Parameters:
- MREG, 1: 1 = register the multiplier product input; 0 = pass-through.
- CREG, 1: 1 = register C; 0 = pass-through.
- OPMODEREG, 1: 1 = register opmode; 0 = pass-through.
- CARRYINREG, 1: 1 = register the selected carry-in; 0 = pass-through.
- PREG, 1: 1 = register the adder result (P); 0 = combinational P.
- CARRYOUTREG, 1: 1 = register carryout; 0 = combinational carryout.
- CARRYINSEL, "OPMODE5": "OPMODE5" = carry-in taken from opmode[5]; "CARRYIN" = carry-in taken from the carryin port.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high; clears all internal registers.
- ce_m  input  1  clock enable, M register.
- ce_c  input  1  clock enable, C register.
- ce_opmode  input  1  clock enable, OPMODE register.
- ce_carryin  input  1  clock enable, CARRYIN register.
- ce_p  input  1  clock enable, P and CARRYOUT registers.
- m  input  36  signed multiplier product.
- c  input  48  C operand.
- pcin  input  48  cascade input from the previous slice.
- dab  input  48  {D[11:0], A[17:0], B[17:0]} concatenation.
- carryin  input  1  external carry-in.
- opmode  input  8  operation select.
- p  output  48  result.
- pcout  output  48  cascade output; always equal to p.
- carryout  output  1  adder carry/borrow bit 48.
- carryoutf  output  1  copy of carryout for fabric routing.

Behaviour:
- Reset: on a clk edge with reset=1, all internal registers clear to 0, regardless of any ce_*.
  - With PREG=1: p=pcout=0.
  - With CARRYOUTREG=1: carryout=carryoutf=0.
  - Reset has priority over ce_*.
- Register rule: each xREG=1 register loads on a clk edge when its ce_* is 1 and holds otherwise. An xREG=0 stage is a wire, and its ce_* is ignored.
- X mux, opmode[1:0]:
  - 00: 0.
  - 01: m sign-extended to 48 bits.
  - 10: P register.
  - 11: dab.
- Z mux, opmode[3:2]:
  - 00: 0.
  - 01: pcin.
  - 10: P register.
  - 11: C (post-CREG).
- P feedback: when PREG=0, the P selections (X=10, Z=10) yield 0, so there is no combinational loop.
- Carry-in:
  - Source is opmode[5] or the carryin port, per CARRYINSEL.
  - Passes through the CARRYINREG stage to give CIN.
- Operation, opmode[7] (opmode[4] and opmode[6] are ignored by this block):
  - opmode[7]=0: R = {0,Z} + {0,X} + CIN.
  - opmode[7]=1: R = {0,Z} − ({0,X} + CIN).
  - R is 49 bits, computed modulo 2^49. p = R[47:0]; carryout = R[48].
- Wrap-around: the 48-bit result wraps silently, with no saturation and no overflow flag.
- Latency from m to p = MREG + PREG cycles. Latency from c to p = CREG + PREG cycles.
- Accumulate: with X=M, Z=P, PREG=1 and ce_p=1, p(n+1) = p(n) + m, one product per cycle.
- Accumulate hold: when ce_p=0, p and carryout hold their values while upstream registers continue to load under their own enables.
- Simultaneous events:
  - reset and ce_* both asserted: reset wins.
  - opmode change while accumulating: the new selection takes effect after OPMODEREG cycles.
- Reset mid-accumulation: p returns to 0 on the next edge; accumulation resumes from 0 on the following cycle.

Test Plan:
- Default params, reset=1 for 2 cycles with all ce=1 and nonzero inputs -> p=0, carryout=0. After release with opmode=0x0D (X=M, Z=C, add), m=100, c=5 -> p=105 two edges after inputs settle.
- Accumulate: opmode=0x09 (X=M, Z=P), m=3, ce all 1, from p=0 -> p=3, 6, 9, 12 on consecutive cycles. Then ce_p=0 for 2 cycles -> p holds 12.
- Subtract with borrow: opmode=0x8F (X=dab, Z=C, subtract), c=0, dab=1 -> p=0xFFFF_FFFF_FFFF, carryout=1.
- Wrap with carry: opmode=0x0F (X=dab, Z=C), c=0xFFFF_FFFF_FFFF, dab=1 -> p=0, carryout=1. With opmode=0x2F (opmode[5]=1, CARRYINSEL=OPMODE5), c=0, dab=0 -> p=1.
- Sign extension: m=0x8_0000_0000 (−2^35), opmode=0x01 -> p=0xFFF8_0000_0000. Cascade: opmode=0x04 (Z=pcin), pcin=0x1234 -> p=pcout=0x1234.
- All registers 0 (MREG=CREG=OPMODEREG=CARRYINREG=PREG=CARRYOUTREG=0): opmode=0x0D, m=7, c=2 -> p=9 in the same cycle. opmode=0x02 (X=P) -> p=0.
